// File: rtl/qsram_access_scheduler.sv
// qsram_access_scheduler: arbitrates read, write and refresh onto one QSRAM array with registered single-cycle strobes
module qsram_access_scheduler #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int REFRESH_INTERVAL = 64,
  parameter int MAX_DEFER = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReadRequest,
  input  logic [ADDR_WIDTH-1:0] ReadAddress,
  output logic                  ReadGrant,
  output logic                  ReadValid,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteRequest,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  WriteGrant,
  output logic [ADDR_WIDTH-1:0] ArrayAddress,
  output logic [DATA_WIDTH-1:0] ArrayWriteData,
  input  logic [DATA_WIDTH-1:0] ArrayReadData,
  output logic                  ReadEdge,
  output logic                  WriteEdge,
  output logic                  RefreshEdge,
  output logic                  RefreshMissed
);
  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int DW = $clog2(MAX_DEFER + 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;
  typedef enum logic [1:0] {READ, WRITE, REFRESH} op_t;
  state_t state;
  op_t op;
  logic [TW-1:0] timer;
  logic [DW-1:0] defer;
  logic [ADDR_WIDTH-1:0] row;
  logic pending, last_was_write;
  logic tc, idle, sel_ref, sel_wr, take_ref, go;
  always_comb begin
    tc = timer == TW'(REFRESH_INTERVAL - 1);
    idle = state == IDLE;
    sel_ref = pending && (defer == DW'(MAX_DEFER) || !(ReadRequest || WriteRequest));
    // on contention the write wins unless the previous host grant was a write
    sel_wr = WriteRequest && (!ReadRequest || !last_was_write);
    take_ref = idle && sel_ref;
    go = idle && (sel_ref || ReadRequest || WriteRequest);
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      op <= READ;
      timer <= '0;
      defer <= '0;
      row <= '0;
      pending <= 1'b0;
      last_was_write <= 1'b0;
      ReadGrant <= 1'b0;
      ReadValid <= 1'b0;
      ReadData <= '0;
      WriteGrant <= 1'b0;
      ArrayAddress <= '0;
      ArrayWriteData <= '0;
      ReadEdge <= 1'b0;
      WriteEdge <= 1'b0;
      RefreshEdge <= 1'b0;
      RefreshMissed <= 1'b0;
    end else begin
      timer <= tc ? '0 : timer + 1'b1;
      pending <= tc ? 1'b1 : (take_ref ? 1'b0 : pending);
      // a terminal count while a refresh is still unserviced means one was lost
      RefreshMissed <= RefreshMissed | (tc && pending && !take_ref);
      defer <= take_ref ? '0 : (idle && pending && defer != DW'(MAX_DEFER)) ? defer + 1'b1 : defer;
      ReadGrant <= 1'b0;
      WriteGrant <= 1'b0;
      ReadValid <= 1'b0;
      ReadEdge <= 1'b0;
      WriteEdge <= 1'b0;
      RefreshEdge <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state <= SETUP;
          op <= sel_ref ? REFRESH : sel_wr ? WRITE : READ;
          ArrayAddress <= sel_ref ? row : sel_wr ? WriteAddress : ReadAddress;
          ArrayWriteData <= (!sel_ref && sel_wr) ? WriteData : ArrayWriteData;
          last_was_write <= sel_ref ? last_was_write : sel_wr;
          ReadGrant <= !sel_ref && !sel_wr;
          WriteGrant <= !sel_ref && sel_wr;
        end
        SETUP: begin
          state <= STROBE;
          ReadEdge <= op == READ;
          WriteEdge <= op == WRITE;
          RefreshEdge <= op == REFRESH;
        end
        STROBE: begin
          state <= IDLE;
          ReadValid <= op == READ;
          ReadData <= op == READ ? ArrayReadData : ReadData;
          row <= op == REFRESH ? row + 1'b1 : row;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qsram_access_scheduler.sv
// tb_qsram_access_scheduler: directed scenarios with a grant-order and read-data scoreboard
module tb_qsram_access_scheduler;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;
  logic ReadRequest = 1'b0, WriteRequest = 1'b0;
  logic [3:0] ReadAddress = '0, WriteAddress = '0, WriteData = '0;
  logic ReadGrant, ReadValid, WriteGrant, ReadEdge, WriteEdge, RefreshEdge, RefreshMissed;
  logic [3:0] ReadData, ArrayAddress, ArrayWriteData, ArrayReadData;
  logic m_rreq = 1'b0, m_wreq = 1'b0;
  logic [3:0] m_zero = '0;
  logic m_rg, m_rv, m_wg, m_re, m_we, m_fe, m_missed;
  logic [3:0] m_rd, m_aa, m_awd;
  logic [3:0] mem [16];
  int checks = 0, errors = 0, ev;
  int ev_q[$];
  logic [3:0] rd_q[$];
  bit seq_on = 1'b0;

  qsram_access_scheduler dut (
    .Clock(Clock), .Reset(Reset),
    .ReadRequest(ReadRequest), .ReadAddress(ReadAddress), .ReadGrant(ReadGrant),
    .ReadValid(ReadValid), .ReadData(ReadData),
    .WriteRequest(WriteRequest), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .WriteGrant(WriteGrant), .ArrayAddress(ArrayAddress), .ArrayWriteData(ArrayWriteData),
    .ArrayReadData(ArrayReadData), .ReadEdge(ReadEdge), .WriteEdge(WriteEdge),
    .RefreshEdge(RefreshEdge), .RefreshMissed(RefreshMissed)
  );

  qsram_access_scheduler #(.REFRESH_INTERVAL(8)) dut_m (
    .Clock(Clock), .Reset(Reset),
    .ReadRequest(m_rreq), .ReadAddress(m_zero), .ReadGrant(m_rg),
    .ReadValid(m_rv), .ReadData(m_rd),
    .WriteRequest(m_wreq), .WriteAddress(m_zero), .WriteData(m_zero),
    .WriteGrant(m_wg), .ArrayAddress(m_aa), .ArrayWriteData(m_awd),
    .ArrayReadData(m_zero), .ReadEdge(m_re), .WriteEdge(m_we),
    .RefreshEdge(m_fe), .RefreshMissed(m_missed)
  );

  always @(posedge Clock)
    if (Reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (WriteEdge) mem[ArrayAddress] <= ArrayWriteData;
  assign ArrayReadData = mem[ArrayAddress];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  // event codes: 1 write grant, 2 read grant, 3 refresh strobe
  always @(negedge Clock) begin
    chk("strobe_onehot", 32'($countones({ReadEdge, WriteEdge, RefreshEdge}) <= 1), 1);
    if (ReadValid && rd_q.size() > 0) chk("read_data", ReadData, rd_q.pop_front());
    if (seq_on && (WriteGrant || ReadGrant || RefreshEdge)) begin
      ev = WriteGrant ? 1 : ReadGrant ? 2 : 3;
      if (ev_q.size() == 0) chk("grant_extra", ev, 0);
      else chk("grant_seq", ev, ev_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic stale;
    repeat (3) @(negedge Clock);
    chk("reset_outputs", {ReadGrant, ReadValid, ReadData, WriteGrant, ArrayAddress, ArrayWriteData,
        ReadEdge, WriteEdge, RefreshEdge, RefreshMissed}, 0);
    Reset = 1'b0;
    repeat (65) @(negedge Clock);
    chk("refresh_early", RefreshEdge, 0);
    for (int k = 0; k < 17; k++) begin
      @(negedge Clock);
      chk("refresh_edge", RefreshEdge, 1);
      chk("refresh_row", ArrayAddress, k % 16);
      if (k < 16) repeat (63) @(negedge Clock);
    end
    chk("refresh_missed_idle", RefreshMissed, 0);

    @(negedge Clock);
    WriteRequest = 1'b1; WriteAddress = 4'd5; WriteData = 4'hA;
    n = 0;
    while (!WriteGrant && n < 10) begin @(negedge Clock); n++; end
    chk("write_grant", WriteGrant, 1);
    chk("write_setup_no_edge", WriteEdge, 0);
    WriteRequest = 1'b0;
    @(negedge Clock);
    chk("write_edge", WriteEdge, 1);
    chk("write_addr", ArrayAddress, 5);
    chk("write_data", ArrayWriteData, 4'hA);
    @(negedge Clock);
    ReadRequest = 1'b1; ReadAddress = 4'd5;
    rd_q.push_back(4'hA);
    @(negedge Clock);
    chk("read_grant", ReadGrant, 1);
    chk("read_valid_early", ReadValid, 0);
    ReadRequest = 1'b0;
    @(negedge Clock);
    chk("read_edge", ReadEdge, 1);
    chk("read_addr", ArrayAddress, 5);
    @(negedge Clock);
    chk("read_valid", ReadValid, 1);
    chk("read_data_direct", ReadData, 4'hA);
    @(negedge Clock);
    chk("read_valid_pulse", ReadValid, 0);
    chk("read_queue_empty", rd_q.size(), 0);

    // from reset with both requests held: 30 alternating grants, refresh, then alternation resumes
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("reset_async_outputs", {ReadGrant, ReadValid, ReadData, WriteGrant, ArrayAddress, ArrayWriteData,
        ReadEdge, WriteEdge, RefreshEdge, RefreshMissed}, 0);
    @(negedge Clock);
    ReadRequest = 1'b1; WriteRequest = 1'b1;
    ReadAddress = 4'd3; WriteAddress = 4'd3; WriteData = 4'd7;
    for (int i = 0; i < 30; i++) ev_q.push_back(i % 2 == 0 ? 1 : 2);
    ev_q.push_back(3);
    ev_q.push_back(1); ev_q.push_back(2); ev_q.push_back(1);
    seq_on = 1'b1;
    Reset = 1'b0;
    for (int i = 0; i < 150 && ev_q.size() > 0; i++) begin @(negedge Clock); #1; end
    seq_on = 1'b0;
    chk("grant_seq_done", ev_q.size(), 0);
    chk("missed_after_defer", RefreshMissed, 0);
    ReadRequest = 1'b0; WriteRequest = 1'b0;

    chk("m_missed_before", m_missed, 0);
    m_rreq = 1'b1; m_wreq = 1'b1;
    repeat (60) @(negedge Clock);
    chk("m_missed_set", m_missed, 1);
    m_rreq = 1'b0; m_wreq = 1'b0;
    repeat (20) @(negedge Clock);
    chk("m_missed_sticky", m_missed, 1);

    @(negedge Clock);
    WriteRequest = 1'b1; WriteAddress = 4'd9; WriteData = 4'hC;
    n = 0;
    while (!WriteGrant && n < 12) begin @(negedge Clock); n++; end
    chk("write2_grant", WriteGrant, 1);
    WriteRequest = 1'b0;
    @(negedge Clock);
    chk("write2_edge", WriteEdge, 1);
    chk("write2_addr", ArrayAddress, 9);
    #2 Reset = 1'b1;
    #1;
    chk("write_edge_async_drop", WriteEdge, 0);
    chk("reset_mid_strobe_outputs", {ReadGrant, ReadValid, ReadData, WriteGrant, ArrayAddress, ArrayWriteData,
        ReadEdge, WriteEdge, RefreshEdge, RefreshMissed}, 0);
    chk("m_missed_cleared", m_missed, 0);
    @(negedge Clock);
    Reset = 1'b0;
    stale = 1'b0;
    repeat (65) begin
      @(negedge Clock);
      stale = stale | ReadGrant | WriteGrant | ReadValid | RefreshEdge;
    end
    chk("post_reset_quiet", stale, 0);
    @(negedge Clock);
    chk("post_reset_refresh", RefreshEdge, 1);
    chk("post_reset_row", ArrayAddress, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qsram_access_scheduler.md
Name: qsram_access_scheduler

Overview:
Sequences a QSRAM cell array's ReadEdge, WriteEdge and RefreshEdge strobes. Arbitrates one read port, one write port and an internal refresh timer onto the single shared array. Every strobe to the array is a registered, single-cycle pulse with address and data held stable around it. Sits between the host-side requesters and the cell array.

Parameters:
ADDR_WIDTH, 4, array row address width; rows = 2**ADDR_WIDTH
DATA_WIDTH, 4, data word width
REFRESH_INTERVAL, 64, cycles between refresh requests (>= 8)
MAX_DEFER, 8, cycles a pending refresh may yield to host traffic (>= 1)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
ReadRequest  in  1  read request; held until ReadGrant
ReadAddress  in  ADDR_WIDTH  read row
ReadGrant  out  1  one-cycle accept pulse for the read
ReadValid  out  1  one-cycle pulse; ReadData valid
ReadData  out  DATA_WIDTH  captured array data
WriteRequest  in  1  write request; held until WriteGrant
WriteAddress  in  ADDR_WIDTH  write row
WriteData  in  DATA_WIDTH  write word
WriteGrant  out  1  one-cycle accept pulse for the write
ArrayAddress  out  ADDR_WIDTH  row to array
ArrayWriteData  out  DATA_WIDTH  data to array
ArrayReadData  in  DATA_WIDTH  array output
ReadEdge  out  1  array read strobe
WriteEdge  out  1  array write strobe
RefreshEdge  out  1  array refresh strobe
RefreshMissed  out  1  sticky overrun flag

Behaviour:
- All outputs are registered. Reset asynchronously forces all outputs, counters and flags to 0 and the state to IDLE, including mid-strobe.
- FSM states: IDLE, SETUP and STROBE. Register Op is one of READ, WRITE or REFRESH.
- Refresh timer counts 0..REFRESH_INTERVAL-1 and wraps. On terminal count it sets RefreshPending.
  - If RefreshPending is already set at terminal count, RefreshMissed is set. RefreshMissed clears only on Reset.
- DeferCount increments each cycle that RefreshPending=1 and the FSM is in IDLE without selecting refresh. It saturates at MAX_DEFER.
- IDLE arbitration is evaluated every cycle, first match wins:
  1. RefreshPending and (DeferCount==MAX_DEFER, or neither request high) -> REFRESH.
  2. Both requests high -> the op not granted last time (LastWasWrite flag, reset value 0, so write wins first).
  3. WriteRequest -> WRITE.
  4. ReadRequest -> READ.
  5. Otherwise stay in IDLE.
- On selection, at the clock edge:
  - Latch ArrayAddress: request address, or RefreshRow for refresh.
  - Latch ArrayWriteData: WriteData for a write.
  - Go to SETUP.
  - For refresh, clear RefreshPending and DeferCount.
- SETUP (1 cycle): matching Grant=1 for read or write; no Grant for refresh. All strobes are 0 and address/data are stable. The requester must deassert its request by the end of this cycle.
- STROBE (1 cycle): exactly one of ReadEdge, WriteEdge or RefreshEdge=1. Then return to IDLE.
  - READ: ArrayReadData is captured into ReadData at the edge ending STROBE. ReadValid=1 for the following cycle.
  - REFRESH: RefreshRow increments mod 2**ADDR_WIDTH at the end of STROBE.
- Read latency: request sampled in IDLE at edge N -> ReadGrant in cycle N+1 -> ReadEdge in N+2 -> ReadValid/ReadData in N+3.
- Throughput: one access per 3 cycles. ArrayAddress and ArrayWriteData hold their values outside an access.
- A timer terminal count during SETUP/STROBE of a refresh sets a new pending request, since pending was cleared on entry.
- Requests arriving outside IDLE wait. A request dropped before its grant is silently abandoned.
- Never more than one strobe is high; strobes are never high outside STROBE.

Test Plan:
- Reset, then idle for 64 cycles -> RefreshEdge pulse at the expected cycle with ArrayAddress=0. After 16 refreshes, ArrayAddress wraps back to 0. RefreshMissed stays 0.
- Write addr 5 data 0xA, then read addr 5 with the array model returning 0xA -> WriteGrant, then one WriteEdge with ArrayAddress=5. ReadValid=1 with ReadData=0xA exactly 3 cycles after the read request is sampled.
- ReadRequest and WriteRequest held continuously -> grants alternate W,R,W,R. No strobe overlap.
- Continuous requests plus a pending refresh -> refresh issued after exactly MAX_DEFER=8 deferred IDLE cycles. It preempts the next host grant.
- REFRESH_INTERVAL=8 with host traffic saturating so refresh cannot complete in time -> RefreshMissed asserts and stays 1 until Reset.
- Reset asserted during the STROBE of a write -> WriteEdge falls immediately, with no clock edge needed. After release, the FSM is in IDLE, the refresh timer restarts from 0, and no stale grant or valid is issued.
